seq_checker: RTL and testbench

//  Checker and scoreboard for the arithmetic stimulus stream our testers drive.

---
 rtl/seq_checker.sv | 126 ++++++++++++
 tb/tb_seq_checker.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_checker.sv
// Stream checker: compares three accepted samples against BASE, BASE*MULT and
// BASE**EXP (all mod 2**WIDTH) and reports pass/fail, error count and first mismatch.
module seq_checker #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned BASE  = 9,
  parameter int unsigned MULT  = 2,
  parameter int unsigned EXP   = 2,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x_in,
  input  logic             x_valid,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       first_err_idx,
  output logic [WIDTH-1:0] last_got
);

  localparam logic [WIDTH-1:0] BASE_W   = WIDTH'(BASE);
  localparam logic [WIDTH-1:0] E0       = WIDTH'(BASE);
  localparam logic [WIDTH-1:0] E1       = WIDTH'(BASE * MULT);
  localparam int unsigned      PREP_LEN = (EXP > 0) ? EXP : 1;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    WAIT0,
    WAIT1,
    WAIT2,
    DONE
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_mul;
  logic [31:0]      prep_cnt;
  logic [WIDTH-1:0] cur_exp;
  logic [1:0]       cur_idx;
  logic             accept;
  logic             launch;

  // acc doubles as the E2 register once PREP has finished
  assign acc_mul = acc * BASE_W;
  assign accept  = ready & x_valid;
  assign launch  = start & ((state == IDLE) | (state == DONE));

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    cur_exp  = E0;
    cur_idx  = 2'd0;
    case (state)
      IDLE:  if (start) state_nx = PREP;
      PREP: begin
        busy = 1'b1;
        if (prep_cnt == PREP_LEN - 1) state_nx = WAIT0;
      end
      WAIT0: begin
        busy  = 1'b1;
        ready = 1'b1;
        if (x_valid) state_nx = WAIT1;
      end
      WAIT1: begin
        busy    = 1'b1;
        ready   = 1'b1;
        cur_exp = E1;
        cur_idx = 2'd1;
        if (x_valid) state_nx = WAIT2;
      end
      WAIT2: begin
        busy    = 1'b1;
        ready   = 1'b1;
        cur_exp = acc;
        cur_idx = 2'd2;
        if (x_valid) state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nx = PREP;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign pass = done & (err_count == '0);
  assign fail = done & (err_count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      acc           <= '0;
      prep_cnt      <= '0;
      err_count     <= '0;
      first_err_idx <= 2'd3;
      last_got      <= '0;
    end else begin
      state <= state_nx;
      if (launch) begin
        acc           <= WIDTH'(1);
        prep_cnt      <= '0;
        err_count     <= '0;
        first_err_idx <= 2'd3;
      end
      if (state == PREP) begin
        prep_cnt <= prep_cnt + 32'd1;
        if (prep_cnt < EXP) acc <= acc_mul;
      end
      if (accept) begin
        last_got <= x_in;
        if (x_in != cur_exp) begin
          if (err_count != '1) err_count <= err_count + 1'b1;
          if (first_err_idx == 2'd3) first_err_idx <= cur_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_checker.sv
// Bench for seq_checker: four parameterisations, table vectors, hand-written
// corner sequences and randomized runs checked against an arithmetic model.
module tb_seq_checker;

  typedef struct packed {
    logic       rdy;
    logic       busy;
    logic       done;
    logic       pass;
    logic       fail;
    logic [3:0] ec;
    logic [1:0] fi;
    logic [7:0] lg;
  } out_t;

  typedef struct {
    int unsigned v0, v1, v2;
    int          gap;
    int          exp_err;
    int          exp_first;
  } vec_t;

  int unsigned p_w   [4] = '{6, 8, 6, 6};
  int unsigned p_exp [4] = '{2, 0, 3, 2};
  int unsigned p_cnt [4] = '{4, 4, 4, 1};

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] st, xv;
  logic [7:0] xin [4];

  logic       r0, b0, d0, p0, f0, r1, b1, d1, p1, f1;
  logic       r2, b2, d2, p2, f2, r3, b3, d3, p3, f3;
  logic [3:0] ec0, ec1, ec2;
  logic [0:0] ec3;
  logic [1:0] fi0, fi1, fi2, fi3;
  logic [5:0] lg0, lg2, lg3;
  logic [7:0] lg1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_checker u0 (
    .clk(clk), .rst(rst), .start(st[0]), .x_in(xin[0][5:0]), .x_valid(xv[0]),
    .ready(r0), .busy(b0), .done(d0), .pass(p0), .fail(f0),
    .err_count(ec0), .first_err_idx(fi0), .last_got(lg0));

  seq_checker #(.WIDTH(8), .EXP(0)) u1 (
    .clk(clk), .rst(rst), .start(st[1]), .x_in(xin[1]), .x_valid(xv[1]),
    .ready(r1), .busy(b1), .done(d1), .pass(p1), .fail(f1),
    .err_count(ec1), .first_err_idx(fi1), .last_got(lg1));

  seq_checker #(.WIDTH(6), .EXP(3)) u2 (
    .clk(clk), .rst(rst), .start(st[2]), .x_in(xin[2][5:0]), .x_valid(xv[2]),
    .ready(r2), .busy(b2), .done(d2), .pass(p2), .fail(f2),
    .err_count(ec2), .first_err_idx(fi2), .last_got(lg2));

  seq_checker #(.CNT_W(1)) u3 (
    .clk(clk), .rst(rst), .start(st[3]), .x_in(xin[3][5:0]), .x_valid(xv[3]),
    .ready(r3), .busy(b3), .done(d3), .pass(p3), .fail(f3),
    .err_count(ec3), .first_err_idx(fi3), .last_got(lg3));

  function automatic out_t get_o(int s);
    out_t o;
    o = '0;
    case (s)
      0: o = '{r0, b0, d0, p0, f0, ec0, fi0, {2'b00, lg0}};
      1: o = '{r1, b1, d1, p1, f1, ec1, fi1, lg1};
      2: o = '{r2, b2, d2, p2, f2, ec2, fi2, {2'b00, lg2}};
      default: o = '{r3, b3, d3, p3, f3, {3'b000, ec3}, fi3, {2'b00, lg3}};
    endcase
    return o;
  endfunction

  // Expected sample k for instance s, straight from the arithmetic definition
  function automatic int unsigned e_val(int s, int k);
    longint unsigned m, v;
    m = 64'd1 << p_w[s];
    case (k)
      0:       v = 64'd9;
      1:       v = 64'd18;
      default: v = 64'd9 ** p_exp[s];
    endcase
    return int'(v % m);
  endfunction

  task automatic chk(string name, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic do_start(int s);
    @(negedge clk);
    st[s] = 1'b1;
    @(negedge clk);
    st[s] = 1'b0;
  endtask

  task automatic wait_ready(int s, output int cyc);
    out_t o;
    cyc = 0;
    o = get_o(s);
    while (!o.rdy && cyc < 50) begin
      @(negedge clk);
      cyc++;
      o = get_o(s);
    end
    if (!o.rdy) chk("ready_timeout", 0, 1);
  endtask

  task automatic send(int s, int unsigned v, int gap);
    int cyc;
    wait_ready(s, cyc);
    xin[s] = 8'(v);
    xv[s]  = 1'b1;
    @(negedge clk);
    xv[s]  = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_done(string tag, int s, int exp_err, int exp_first, int exp_last);
    out_t o;
    o = get_o(s);
    chk({tag, ".done"}, 32'(o.done), 1);
    chk({tag, ".pass"}, 32'(o.pass), (exp_err == 0) ? 1 : 0);
    chk({tag, ".fail"}, 32'(o.fail), (exp_err != 0) ? 1 : 0);
    chk({tag, ".busy"}, 32'(o.busy), 0);
    chk({tag, ".err_count"}, 32'(o.ec), exp_err);
    chk({tag, ".first_err_idx"}, 32'(o.fi), exp_first);
    chk({tag, ".last_got"}, 32'(o.lg), exp_last);
  endtask

  task automatic run(string tag, int s, int unsigned v0, int unsigned v1, int unsigned v2,
                     int gap, int exp_err, int exp_first);
    int cyc;
    int plen;
    do_start(s);
    wait_ready(s, cyc);
    plen = (p_exp[s] > 0) ? int'(p_exp[s]) : 1;
    chk({tag, ".prep_len"}, cyc, plen);
    send(s, v0, gap);
    send(s, v1, gap);
    send(s, v2, gap);
    check_done(tag, s, exp_err, exp_first, int'(v2));
  endtask

  task automatic model_run(string tag, int s, int unsigned v0, int unsigned v1,
                           int unsigned v2, int gap);
    int unsigned v [3];
    int err, first, maxc;
    v = '{v0, v1, v2};
    err = 0;
    first = 3;
    for (int k = 0; k < 3; k++) begin
      if (v[k] != e_val(s, k)) begin
        err++;
        if (first == 3) first = k;
      end
    end
    maxc = (1 << p_cnt[s]) - 1;
    if (err > maxc) err = maxc;
    run(tag, s, v0, v1, v2, gap, err, first);
  endtask

  vec_t vecs [6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    out_t o;
    vecs[0] = '{9, 18, 17, 0, 0, 3};
    vecs[1] = '{9, 19, 17, 2, 1, 1};
    vecs[2] = '{0, 0, 0, 0, 3, 0};
    vecs[3] = '{9, 18, 17, 0, 0, 3};
    vecs[4] = '{9, 18, 16, 1, 1, 2};
    vecs[5] = '{63, 18, 17, 0, 1, 0};

    rst = 1'b1;
    st  = '0;
    xv  = '0;
    for (int i = 0; i < 4; i++) xin[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      o = get_o(s);
      chk($sformatf("reset%0d.outs", s), 32'({o.rdy, o.busy, o.done, o.pass, o.fail}), 0);
      chk($sformatf("reset%0d.err_count", s), 32'(o.ec), 0);
      chk($sformatf("reset%0d.first_err_idx", s), 32'(o.fi), 3);
      chk($sformatf("reset%0d.last_got", s), 32'(o.lg), 0);
    end

    for (int i = 0; i < 6; i++)
      run($sformatf("vec%0d", i), 0, vecs[i].v0, vecs[i].v1, vecs[i].v2,
          vecs[i].gap, vecs[i].exp_err, vecs[i].exp_first);

    // x_valid held high throughout PREP must not be taken
    do_start(0);
    xin[0] = 8'd5;
    xv[0]  = 1'b1;
    repeat (2) @(negedge clk);
    xv[0]  = 1'b0;
    o = get_o(0);
    chk("prep_valid.ready", 32'(o.rdy), 1);
    chk("prep_valid.last_got", 32'(o.lg), 17);
    chk("prep_valid.err_count", 32'(o.ec), 0);
    send(0, 9, 0);
    send(0, 18, 0);
    send(0, 17, 0);
    check_done("prep_valid", 0, 0, 3, 17);

    // start pulsed in WAIT1 is ignored; results then hold in DONE
    do_start(0);
    send(0, 9, 0);
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    o = get_o(0);
    chk("busy_start.busy", 32'(o.busy), 1);
    chk("busy_start.ready", 32'(o.rdy), 1);
    send(0, 18, 0);
    send(0, 17, 0);
    repeat (3) @(negedge clk);
    check_done("busy_start", 0, 0, 3, 17);

    // rst in WAIT1, together with start, aborts to reset state
    do_start(0);
    send(0, 5, 0);
    rst   = 1'b1;
    st[0] = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    st[0] = 1'b0;
    o = get_o(0);
    chk("abort.outs", 32'({o.rdy, o.busy, o.done, o.pass, o.fail}), 0);
    chk("abort.err_count", 32'(o.ec), 0);
    chk("abort.first_err_idx", 32'(o.fi), 3);
    chk("abort.last_got", 32'(o.lg), 0);
    @(negedge clk);
    o = get_o(0);
    chk("abort.idle", 32'({o.rdy, o.busy}), 0);

    run("exp0.pass", 1, 9, 18, 1, 0, 0, 3);
    run("exp0.fail", 1, 9, 18, 0, 1, 1, 2);
    run("exp3.pass", 2, 9, 18, 25, 0, 0, 3);
    run("exp3.fail", 2, 9, 18, 17, 0, 1, 2);
    for (int i = 0; i < 3; i++)
      run($sformatf("sat%0d", i), 3, 0, 0, 0, 0, 1, 0);
    run("sat.pass", 3, 9, 18, 17, 0, 0, 3);

    for (int i = 0; i < 40; i++) begin
      int s, gap;
      int unsigned v [3];
      s   = int'($urandom_range(0, 3));
      gap = int'($urandom_range(0, 2));
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 1) == 0) v[k] = e_val(s, k);
        else v[k] = $urandom_range(0, (1 << p_w[s]) - 1);
      end
      model_run($sformatf("rand%0d", i), s, v[0], v[1], v[2], gap);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
